// File: rtl/regwb_pkg.sv
// Shared constants and entry layout for the register write-back sequencer.
// The optional bypass lookup is enabled by defining REGWB_BYPASS_EN.
package regwb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam int REGWB_DATA_W = 32;

  // Queued write; the FIFO stores entries packed in this same {addr, data} order.
  typedef struct packed {
    logic [REG_ADDR_W-1:0]   addr;
    logic [REGWB_DATA_W-1:0] data;
  } regwb_entry_t;
endpackage

// File: rtl/regwb_fifo.sv
// Circular buffer holding queued register writes. The contents are exposed
// in age order (index 0 = head/oldest) together with a per-slot valid mask.
// This lets the parent search the queue without knowing the pointer values.
module regwb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           push_data,
  output logic [$clog2(DEPTH):0] count,
  output logic [W-1:0]           entries [DEPTH],
  output logic [DEPTH-1:0]       valid_mask
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  // Pointer and occupancy tracking; flush drops everything and overrides push/pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: a slot is only visible while covered by count.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // Age-ordered view: slot gi is the gi-th oldest queued entry.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_view
    logic [PW-1:0] idx;
    assign idx            = rd_ptr + PW'(gi);
    assign entries[gi]    = mem[idx];
    assign valid_mask[gi] = (CW'(gi) < count);
  end
endmodule

// File: rtl/regfile_write_sequencer.sv
// Write-side initiator for the 32-entry register file: accepts write-back
// requests, queues them in order and drives the single write port.
// Define REGWB_BYPASS_EN to build the queued-value bypass lookup; otherwise
// query_hit/query_data are tied to zero.
module regfile_write_sequencer
  import regwb_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wb_valid,
  output logic                   wb_ready,
  input  logic [REG_ADDR_W-1:0]  wb_reg,
  input  logic [N-1:0]           wb_data,
  input  logic                   drain_en,
  input  logic                   flush,
  output logic                   Reg_write_in,
  output logic [REG_ADDR_W-1:0]  Write_Register_1,
  output logic [N-1:0]           Write_Data,
  output logic [$clog2(DEPTH):0] pending_count,
  input  logic [REG_ADDR_W-1:0]  query_reg,
  output logic                   query_hit,
  output logic [N-1:0]           query_data
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = REG_ADDR_W + N;

  logic          push;
  logic          pop;
  logic          has_head;
  logic [EW-1:0] entries [DEPTH];
  logic [DEPTH-1:0] valid_mask;

  // Ready depends only on occupancy and flush, never on the requester.
  assign wb_ready = (pending_count < CW'(DEPTH)) && !flush;
  // Writes to r0 are swallowed: handshake completes but nothing is queued.
  assign push     = wb_valid && wb_ready && (wb_reg != REG_ZERO);

  assign has_head         = (pending_count != '0);
  assign Reg_write_in     = drain_en && has_head;
  assign pop              = Reg_write_in;
  assign Write_Register_1 = has_head ? entries[0][EW-1 -: REG_ADDR_W] : '0;
  assign Write_Data       = has_head ? entries[0][N-1:0] : '0;

  regwb_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .push_data  ({wb_reg, wb_data}),
    .count      (pending_count),
    .entries    (entries),
    .valid_mask (valid_mask)
  );

`ifdef REGWB_BYPASS_EN
  // Scan oldest to newest so the newest matching entry wins; the head being
  // written this cycle is still a valid source.
  always_comb begin
    query_hit  = 1'b0;
    query_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (valid_mask[k] && (query_reg != REG_ZERO) &&
          (entries[k][EW-1 -: REG_ADDR_W] == query_reg)) begin
        query_hit  = 1'b1;
        query_data = entries[k][N-1:0];
      end
    end
  end
`else
  assign query_hit  = 1'b0;
  assign query_data = '0;

  // Without bypass, the lookup port and the queue view beyond the head are unused.
  logic [DEPTH-1:0] unused_entry_bits;
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_unused
    assign unused_entry_bits[gi] = ^entries[gi];
  end
  logic unused_bypass;
  assign unused_bypass = ^{query_reg, valid_mask, unused_entry_bits};
`endif
endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Self-checking bench for regfile_write_sequencer: directed scenarios followed
// by random traffic, all compared against a queue-based reference model.
module tb_regfile_write_sequencer;
  localparam int N     = 32;
  localparam int DEPTH = 4;

  logic         clk;
  logic         reset;
  logic         wb_valid;
  logic         wb_ready;
  logic [4:0]   wb_reg;
  logic [N-1:0] wb_data;
  logic         drain_en;
  logic         flush;
  logic         Reg_write_in;
  logic [4:0]   Write_Register_1;
  logic [N-1:0] Write_Data;
  logic [2:0]   pending_count;
  logic [4:0]   query_reg;
  logic         query_hit;
  logic [N-1:0] query_data;

  regfile_write_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .wb_valid         (wb_valid),
    .wb_ready         (wb_ready),
    .wb_reg           (wb_reg),
    .wb_data          (wb_data),
    .drain_en         (drain_en),
    .flush            (flush),
    .Reg_write_in     (Reg_write_in),
    .Write_Register_1 (Write_Register_1),
    .Write_Data       (Write_Data),
    .pending_count    (pending_count),
    .query_reg        (query_reg),
    .query_hit        (query_hit),
    .query_data       (query_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [4:0]   a;
    logic [N-1:0] d;
  } ent_t;

  ent_t q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output with what the queue model says it should be now.
  task automatic check_model();
    logic         e_hit;
    logic [N-1:0] e_qd;
    e_hit = 1'b0;
    e_qd  = '0;
`ifdef REGWB_BYPASS_EN
    if (query_reg != 5'd0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].a == query_reg) begin
          e_hit = 1'b1;
          e_qd  = q[i].d;
          break;
        end
      end
    end
`endif
    check("wb_ready", 64'(wb_ready), 64'((q.size() < DEPTH) && !flush));
    check("Reg_write_in", 64'(Reg_write_in), 64'(drain_en && (q.size() != 0)));
    check("Write_Register_1", 64'(Write_Register_1), (q.size() != 0) ? 64'(q[0].a) : 64'd0);
    check("Write_Data", 64'(Write_Data), (q.size() != 0) ? 64'(q[0].d) : 64'd0);
    check("pending_count", 64'(pending_count), 64'(q.size()));
    check("query_hit", 64'(query_hit), 64'(e_hit));
    check("query_data", 64'(query_data), 64'(e_qd));
  endtask

  // One clock cycle: drive inputs, check outputs, advance the model, take the edge.
  task automatic cycle(input logic v, input logic [4:0] r, input logic [N-1:0] d,
                       input logic de, input logic fl, input logic [4:0] qr);
    logic ready;
    ent_t e;
    wb_valid  = v;
    wb_reg    = r;
    wb_data   = d;
    drain_en  = de;
    flush     = fl;
    query_reg = qr;
    #1;
    check_model();
    ready = (q.size() < DEPTH) && !fl;
    if (de && q.size() != 0)
      $display("[TB] t=%0t commit r%0d <= %08h", $time, q[0].a, q[0].d);
    if (fl) begin
      q.delete();
    end else begin
      if (de && q.size() != 0) void'(q.pop_front());
      if (v && ready && r != 5'd0) begin
        e.a = r;
        e.d = d;
        q.push_back(e);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b0;
    wb_valid  = 1'b0;
    wb_reg    = '0;
    wb_data   = '0;
    drain_en  = 1'b0;
    flush     = 1'b0;
    query_reg = '0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    check("rst_ready", 64'(wb_ready), 64'd1);
    check("rst_we", 64'(Reg_write_in), 64'd0);
    check("rst_addr", 64'(Write_Register_1), 64'd0);
    check("rst_data", 64'(Write_Data), 64'd0);
    check("rst_count", 64'(pending_count), 64'd0);
    check("rst_hit", 64'(query_hit), 64'd0);
    check("rst_qdata", 64'(query_data), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Single write latency: accept at edge k, commit during cycle k+1
    cycle(1, 5'd5, 32'h0000_00AA, 1, 0, 0);
    cycle(0, 5'd0, 32'h0, 1, 0, 0);
    cycle(0, 5'd0, 32'h0, 1, 0, 0);

    // Fill with drain off, then drain four in order
    for (int i = 1; i <= 4; i++) cycle(1, 5'(i), 32'(i * 'h11), 0, 0, 0);
    cycle(1, 5'd9, 32'h99, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 5'd0, 32'h0, 1, 0, 0);

    // Full queue, then sustained push+pop across pointer wrap
    for (int i = 1; i <= 4; i++) cycle(1, 5'(i + 10), 32'(i), 0, 0, 0);
    for (int i = 0; i < 12; i++) cycle(1, 5'(i % 30 + 1), 32'h1000 + 32'(i), 1, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 5'd0, 32'h0, 1, 0, 0);

    // Write to r0 is consumed without queuing
    cycle(1, 5'd0, 32'hDEAD, 1, 0, 0);
    cycle(0, 5'd0, 32'h0, 1, 0, 0);

    // Bypass: newest of two r7 writes, and r0 never hits
    cycle(1, 5'd7, 32'h1, 0, 0, 0);
    cycle(1, 5'd7, 32'h2, 0, 0, 7);
    cycle(0, 5'd0, 32'h0, 0, 0, 7);
    cycle(0, 5'd0, 32'h0, 0, 0, 0);
    cycle(0, 5'd0, 32'h0, 1, 0, 7);
    cycle(0, 5'd0, 32'h0, 1, 0, 7);

    // Flush with three queued: nothing further is written
    for (int i = 0; i < 3; i++) cycle(1, 5'(i + 20), 32'hF0 + 32'(i), 0, 0, 21);
    cycle(1, 5'd30, 32'hBAD, 0, 1, 21);
    for (int i = 0; i < 3; i++) cycle(0, 5'd0, 32'h0, 1, 0, 21);

    // Asynchronous reset in the middle of a drain
    for (int i = 0; i < 3; i++) cycle(1, 5'(i + 3), 32'hC0 + 32'(i), 0, 0, 3);
    cycle(0, 5'd0, 32'h0, 1, 0, 3);
    reset = 1'b0;
    #1;
    q.delete();
    check("mid_rst_we", 64'(Reg_write_in), 64'd0);
    check("mid_rst_addr", 64'(Write_Register_1), 64'd0);
    check("mid_rst_data", 64'(Write_Data), 64'd0);
    check("mid_rst_count", 64'(pending_count), 64'd0);
    check("mid_rst_hit", 64'(query_hit), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cycle(0, 5'd0, 32'h0, 1, 0, 3);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 32'($urandom),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 24) == 0),
            5'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 6; i++) cycle(0, 5'd0, 32'h0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
